out_reg: RTL and testbench



---
 rtl/out_reg.sv | 61 ++++++
 tb/tb_out_reg.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/out_reg.sv
// Stage-x2 to stage-x3 output pipeline register: delays stall, valid strobe and data
// by one clock, holds the last emitted word and counts accepted words.
package out_reg_pkg;
    typedef logic [15:0] t_data;
endpackage

module out_reg #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              stalled,
    input  logic              dataoutvx2,
    input  logic [DATA_W-1:0] dataoutx2,
    output logic              stalledx3,
    output logic              dataoutvx3,
    output logic [DATA_W-1:0] dataoutx3,
    output logic [CNT_W-1:0]  outcount
);

    logic              stall_q, stall_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic              accept;

    // A stalled stage-x2 slot is a bubble, so stall overrides the valid strobe.
    assign accept = dataoutvx2 & ~stalled;

    always_comb begin
        stall_d = stalled;
        valid_d = accept;
        data_d  = data_q;
        cnt_d   = cnt_q;
        if (accept) begin
            data_d = dataoutx2;
            cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            stall_q <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            stall_q <= stall_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign stalledx3  = stall_q;
    assign dataoutvx3 = valid_q;
    assign dataoutx3  = data_q;
    assign outcount   = cnt_q;

endmodule

// File: tb/tb_out_reg.sv
// Self-checking bench for out_reg: directed scenarios plus randomized traffic
// against a word-level reference model.
module tb_out_reg;
    logic        clock;
    logic        resetN;
    logic        stalled;
    logic        dataoutvx2;
    logic [15:0] dataoutx2;
    logic        stalledx3;
    logic        dataoutvx3;
    logic [15:0] dataoutx3;
    logic [15:0] outcount;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: what stage x3 should show, in word-level terms.
    bit          m_stall;
    bit          m_strobe;
    logic [15:0] m_last_word;
    int          m_words;

    out_reg #(.DATA_W(16), .CNT_W(16)) dut (
        .clock      (clock),
        .resetN     (resetN),
        .stalled    (stalled),
        .dataoutvx2 (dataoutvx2),
        .dataoutx2  (dataoutx2),
        .stalledx3  (stalledx3),
        .dataoutvx3 (dataoutvx3),
        .dataoutx3  (dataoutx3),
        .outcount   (outcount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [33:0] observed();
        return {stalledx3, dataoutvx3, dataoutx3, outcount};
    endfunction

    function automatic logic [33:0] expected();
        logic [15:0] cnt;
        cnt = 16'(m_words % 65536);
        return {m_stall, m_strobe, m_last_word, cnt};
    endfunction

    task automatic model_clear();
        m_stall     = 0;
        m_strobe    = 0;
        m_last_word = 16'h0000;
        m_words     = 0;
    endtask

    // Advance one rising edge, update the model from the inputs that edge saw, settle.
    task automatic tick();
        bit s, v;
        logic [15:0] d;
        s = stalled; v = dataoutvx2; d = dataoutx2;
        @(posedge clock);
        if (resetN) begin
            m_stall  = s;
            m_strobe = !s && v;
            if (!s && v) begin
                m_last_word = d;
                m_words++;
            end
        end
        #1;
    endtask

    task automatic drive(input bit s, input bit v, input logic [15:0] d);
        stalled = s; dataoutvx2 = v; dataoutx2 = d;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        drive(1, 1, 16'hBEEF);
        model_clear();
        #2;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (observed() !== 34'h0) begin
                tests_failed++;
                $display("FAIL reset_hold edge %0d: got %h want %h", i, observed(), 34'h0);
            end
        end
        resetN = 1'b1;
        tick();
        tests_run++;
        if (observed() !== {1'b1, 1'b0, 16'h0000, 16'h0000}) begin
            tests_failed++;
            $display("FAIL reset_release: got %h want %h", observed(), {1'b1, 1'b0, 16'h0000, 16'h0000});
        end
    endtask

    task automatic test_single();
        drive(0, 1, 16'h1234);
        tick();
        drive(0, 0, 16'hFFFF);
        tests_run++;
        if (observed() !== {1'b0, 1'b1, 16'h1234, 16'h0001}) begin
            tests_failed++;
            $display("FAIL single_word: got %h want %h", observed(), {1'b0, 1'b1, 16'h1234, 16'h0001});
        end
        tick();
        tests_run++;
        if (observed() !== {1'b0, 1'b0, 16'h1234, 16'h0001}) begin
            tests_failed++;
            $display("FAIL single_hold: got %h want %h", observed(), {1'b0, 1'b0, 16'h1234, 16'h0001});
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] base;
        base = outcount;
        for (int i = 1; i <= 3; i++) begin
            drive(0, 1, 16'(i));
            tick();
            tests_run++;
            if (observed() !== {1'b0, 1'b1, 16'(i), 16'(base + 16'(i))}) begin
                tests_failed++;
                $display("FAIL back_to_back word %0d: got %h want %h", i, observed(),
                         {1'b0, 1'b1, 16'(i), 16'(base + 16'(i))});
            end
        end
        drive(0, 0, 16'h0000);
        tick();
    endtask

    task automatic test_stall();
        logic [15:0] w, c;
        w = m_last_word; c = 16'(m_words % 65536);
        drive(1, 1, 16'hAAAA);
        tick();
        tests_run++;
        if (observed() !== {1'b1, 1'b0, w, c}) begin
            tests_failed++;
            $display("FAIL stall_drops_word: got %h want %h", observed(), {1'b1, 1'b0, w, c});
        end
        drive(0, 0, 16'h0000);
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1, 16'($urandom));
            tick();
            tests_run++;
            if (observed() !== expected()) begin
                tests_failed++;
                $display("FAIL random cycle %0d: got %h want %h", i, observed(), expected());
            end
        end
    endtask

    task automatic test_wrap();
        resetN = 1'b0;
        model_clear();
        #1;
        resetN = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            drive(0, 1, 16'(i));
            tick();
        end
        tests_run++;
        if (outcount !== 16'hFFFF) begin
            tests_failed++;
            $display("FAIL wrap_preset: got %h want %h", outcount, 16'hFFFF);
        end
        drive(0, 1, 16'hC0DE);
        tick();
        tests_run++;
        if (observed() !== {1'b0, 1'b1, 16'hC0DE, 16'h0000}) begin
            tests_failed++;
            $display("FAIL wrap_rollover: got %h want %h", observed(), {1'b0, 1'b1, 16'hC0DE, 16'h0000});
        end
        drive(0, 0, 16'h0000);
        tick();
    endtask

    task automatic test_reset_midstream();
        drive(0, 1, 16'h5555);
        tick();
        tests_run++;
        if (observed() !== expected() || dataoutvx3 !== 1'b1) begin
            tests_failed++;
            $display("FAIL midstream_setup: got %h want %h", observed(), expected());
        end
        #2;
        resetN = 1'b0;
        model_clear();
        #1;
        tests_run++;
        if (observed() !== 34'h0) begin
            tests_failed++;
            $display("FAIL midstream_async_clear: got %h want %h", observed(), 34'h0);
        end
        #1;
        resetN = 1'b1;
        drive(0, 0, 16'h0000);
        tick();
        tests_run++;
        if (observed() !== 34'h0) begin
            tests_failed++;
            $display("FAIL midstream_not_counted: got %h want %h", observed(), 34'h0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_random();
        test_reset_midstream();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
